// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word then payload MSB first; SEQ_FRAME_TX_PARITY_EN appends an even-parity bit.
// Latency: first sync bit one cycle after the accepting edge; frame is SYNC_W+DATA_W (+1 with parity) cycles.
// Backpressure: in_ready only while idle or on the final frame bit, so back-to-back frames are gapless.
module seq_frame_tx #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1101,
  parameter logic              IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_last
);

  localparam int MAX_N = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] SYNC_TOP = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_TOP = CNT_W'(DATA_W - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD, ST_PARITY} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               xfer;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = IDLE_LVL;
    out_sof   = 1'b0;
    out_last  = 1'b0;
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_SYNC: begin
        out_valid = 1'b1;
        out_bit   = |(SYNC_WORD & (SYNC_W'(1) << idx_q));
        out_sof   = (idx_q == SYNC_TOP);
        if (idx_q == '0) begin
          state_d = ST_PAYLOAD;
          idx_d   = DATA_TOP;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
      ST_PAYLOAD: begin
        out_valid = 1'b1;
        out_bit   = shreg_q[DATA_W-1];
        shreg_d   = shreg_q << 1;
        if (idx_q == '0) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_d  = ST_PARITY;
`else
          out_last = 1'b1;
          in_ready = 1'b1;
          state_d  = ST_IDLE;
`endif
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      ST_PARITY: begin
        out_valid = 1'b1;
        out_bit   = parity_q;
        out_last  = 1'b1;
        in_ready  = 1'b1;
        state_d   = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A transfer is only possible on an in_ready cycle and always starts a fresh frame.
    xfer = in_valid && in_ready;
    if (xfer) begin
      state_d  = ST_SYNC;
      idx_d    = SYNC_TOP;
      shreg_d  = in_data;
`ifdef SEQ_FRAME_TX_PARITY_EN
      parity_d = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shreg_q  <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter. Emits a fixed sync word followed by a parallel payload serialised MSB first, one bit per clock.
- Transmit-side counterpart of the team's serial sequence detectors. Its out_bit stream feeds a detector's in_bit directly, with a default sync of 1101.
- Sits between a parallel producer (valid/ready) and a single-bit serial line.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- SYNC_W, 4, sync word width in bits (>=1).
- SYNC_WORD, 4'b1101, sync pattern, transmitted MSB first.
- IDLE_LVL, 1'b0, out_bit level whenever out_valid=0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a payload on in_data.
- in_data  input  DATA_W  payload to send.
- in_ready  output  1  transmitter can accept a payload this cycle.
- out_bit  output  1  serial line.
- out_valid  output  1  out_bit carries a frame bit this cycle.
- out_sof  output  1  first sync bit of a frame.
- out_last  output  1  final bit of a frame.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, counters=0, shift register=0.
  - in_ready=1, out_bit=IDLE_LVL, out_valid=0, out_sof=0, out_last=0.
- All outputs are registered (Moore style) and depend only on state, counter and shift register.
- Handshake:
  - Transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_data is captured into an internal shift register at that edge. Later changes to in_data have no effect.
  - in_valid without in_ready: no capture, no state change. The producer holds in_valid/in_data.
- FSM states:
  - IDLE:
    - in_ready=1, out_valid=0, out_bit=IDLE_LVL.
    - On transfer -> SYNC with bit index=SYNC_W-1.
  - SYNC:
    - out_valid=1, out_bit=SYNC_WORD[index]. out_sof=1 when index=SYNC_W-1.
    - Index decrements each cycle. After index 0 -> PAYLOAD with index=DATA_W-1.
  - PAYLOAD:
    - out_valid=1, out_bit=shift register MSB; shift left each cycle.
    - On the last payload bit (index 0): out_last=1 and in_ready=1.
    - If a transfer occurs in that cycle -> SYNC (new frame, no gap). Otherwise -> IDLE.
- Latency: first sync bit appears the cycle after the accepting edge. Frame length is SYNC_W+DATA_W cycles (plus 1 with PARITY_EN).
- in_ready=0 during SYNC and PAYLOAD, except on the final frame bit.
- Back-to-back frames are gapless: out_valid stays 1 and out_sof immediately follows out_last.
- Boundary cases:
  - DATA_W=1: PAYLOAD lasts one cycle, with out_last and in_ready both high.
  - SYNC_W=1: out_sof on the single sync cycle.
- Reset mid-frame: frame aborted immediately, no partial continuation after release. The first post-reset cycle is IDLE with in_ready=1.
- The bit counter is sized to hold max(SYNC_W, DATA_W) - 1. No wrap-around beyond that range.
- Payload bits matching SYNC_WORD are not escaped. Framing integrity is the receiver's concern.

Optional Feature:
- Macro: SEQ_FRAME_TX_PARITY_EN.
- Defined:
  - An extra PARITY state follows PAYLOAD, with out_bit = XOR of the captured payload (even parity).
  - out_last and the in_ready back-to-back window move to the PARITY cycle. PAYLOAD index 0 no longer asserts them.
  - Frame length becomes SYNC_W+DATA_W+1.
  - The parity value is computed at capture and held in a register.
- Undefined: no PARITY state, no parity logic. Behaviour exactly as above.

Test Plan:
- Reset, then in_valid=1 with in_data=8'hA5 for one cycle -> from the next cycle out_bit=1,1,0,1,1,0,1,0,0,1,0,1. out_valid=1 for 12 cycles, out_sof on cycle 1, out_last on cycle 12, then out_bit=0 and out_valid=0.
- in_valid held high with 8'h3C then 8'hFF accepted on the out_last cycle -> 24 consecutive valid bits 1101_00111100_1101_11111111, no idle cycle, out_sof on cycle 13.
- in_valid=1 with in_data changing to 8'h00 during SYNC of an 8'hA5 frame -> in_ready=0, no second capture, 8'hA5 payload is transmitted unchanged.
- rst_n pulsed low during payload bit 3 of 8'hF0 -> out_valid=0 and out_bit=0 immediately. After release: in_ready=1, nothing transmitted until the next transfer.
- With SEQ_FRAME_TX_PARITY_EN defined: 8'hA5 -> 13 bits ending in parity 0. 8'h07 -> parity bit 1. out_last on the parity cycle only.
- Loopback into the team's 1101 sequence detector with 8'h00 payload -> detector asserts detected exactly once per frame.
